// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: pipeline (port 0) has
// priority, the loader (port 1) is forced through after STARVE_MAX denied cycles.
module dm_arbiter #(
  parameter int STARVE_MAX = 4,
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [2:0]    p0_type,
  input  logic [31:0]   p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_stall,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [2:0]    p1_type,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic [31:0]   p1_rdata,
  output logic          p1_rvalid,
  output logic          p1_err,
  output logic          dm_wr,
  output logic [2:0]    dm_type,
  output logic [31:0]   dm_addr,
  output logic [31:0]   dm_din,
  input  logic [31:0]   dm_dout,
  output logic          dbg_mode,
  output logic [SW-1:0] dbg_starve
);

  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF   = 3'd1;
  localparam logic [2:0] DM_HALF_U = 3'd2;

  typedef enum logic {PRI0 = 1'b0, FORCE1 = 1'b1} mode_t;

  mode_t         mode;
  logic [SW-1:0] starve;
  logic [SW-1:0] starve_inc;
  logic          p0_mis;
  logic          p1_mis;

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    logic m;
    case (t)
      DM_WORD:            m = (a != 2'b00);
      DM_HALF, DM_HALF_U: m = a[0];
      default:            m = 1'b0;
    endcase
    return m;
  endfunction

  // Handshake: a request (req plus payload) is held by its owner until the
  // matching gnt is seen; the access takes place in the cycle gnt is high.
  assign p0_gnt   = (mode == PRI0) & p0_req;
  assign p1_gnt   = (mode == FORCE1) ? p1_req : (p1_req & ~p0_req);
  assign p0_stall = p0_req & ~p0_gnt;
  assign p0_rdata = dm_dout;

  assign p0_mis = misaligned(p0_type, p0_addr[1:0]);
  assign p1_mis = misaligned(p1_type, p1_addr[1:0]);
  assign p0_err = p0_gnt & p0_mis;
  assign p1_err = p1_gnt & p1_mis;

  // Port 0 drives the memory bus whenever port 1 is not granted.
  assign dm_type = p1_gnt ? p1_type  : p0_type;
  assign dm_addr = p1_gnt ? p1_addr  : p0_addr;
  assign dm_din  = p1_gnt ? p1_wdata : p0_wdata;
  assign dm_wr   = p1_gnt ? (p1_we & ~p1_mis) : (p0_gnt & p0_we & ~p0_mis);

  assign starve_inc = starve + 1'b1;
  assign dbg_mode   = mode;
  assign dbg_starve = starve;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode   <= PRI0;
      starve <= '0;
    end else begin
      case (mode)
        PRI0: begin
          if (p1_req & ~p1_gnt) begin
            if (starve_inc == SW'(STARVE_MAX)) begin
              mode   <= FORCE1;
              starve <= '0;
            end else begin
              starve <= starve_inc;
            end
          end else begin
            starve <= '0;
          end
        end
        FORCE1: begin
          mode   <= PRI0;
          starve <= '0;
        end
        default: begin
          mode   <= PRI0;
          starve <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p1_rdata  <= '0;
      p1_rvalid <= 1'b0;
    end else if (p1_gnt & ~p1_we & ~p1_mis) begin
      p1_rdata  <= dm_dout;
      p1_rvalid <= 1'b1;
    end else begin
      p1_rvalid <= 1'b0;
    end
  end

endmodule
